fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction fetch buffer between the ibus response path and the decode pipeline register.
- Generalises the single-entry fetched-instruction save register into a DEPTH-entry in-order queue.
- Adds credit-based fetch throttling, multiple outstanding ibus requests, flush with stale-response dropping, and optional same-cycle bypass.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- OUTSTANDING, 1, maximum number of ibus requests in flight; at least 1.
- PC_W, 64, PC width.
- INSTR_W, 32, instruction width.
- BYPASS, 1, 1 = empty queue forwards a fresh response to the output in the same cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- flush  in  1  redirect (branch, mret or trap): discard all entries and mark in-flight responses stale.
- req_issue  in  1  fetch stage launches an ibus request this cycle; legal only when fetch_allow=1.
- fetch_allow  out  1  credit available to issue a request.
- in_valid  in  1  ibus data_ok beat for the oldest outstanding request.
- in_pc  in  PC_W  PC of the response.
- in_instr  in  INSTR_W  instruction word.
- in_exc  in  1  fetch exception (misaligned PC).
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode accepts (decode not stalled).
- out_pc  out  PC_W  head PC.
- out_instr  out  INSTR_W  head instruction.
- out_exc  out  1  head exception flag.
- count  out  clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, async): count=0, head and tail pointers=0, pending=0, stale=0, overflow=0. Outputs: out_valid=0, out_pc/out_instr/out_exc=0, fetch_allow=1. All entry storage cleared.
- pending: count of in-flight requests, width clog2(OUTSTANDING+1).
  - +1 on req_issue.
  - −1 on in_valid.
- stale: subset of pending that belongs to pre-flush requests.
  - A response with stale>0 is dropped and decrements stale; it is not enqueued.
  - Responses return in issue order, so stale responses always arrive first.
- fetch_allow = (count + pending < DEPTH) && (pending < OUTSTANDING). Combinational from registered state only.
- Accepted response: in_valid && stale==0 && !flush.
- Enqueue: an accepted response is written at tail, unless it is bypassed.
- Bypass: when BYPASS=1, count==0 and a response is accepted, the output shows it combinationally (out_valid=1, fields from in_*).
  - If out_ready=1 that cycle, the response is consumed and not stored.
  - Otherwise it is stored.
- When BYPASS=0, a response appears at the output one cycle after the in_valid cycle.
- out_valid = !flush && (count>0 || bypass case). Output fields come from head when count>0; they are 0 when out_valid=0.
- Dequeue: out_valid && out_ready. Head advances and count decrements.
- Simultaneous enqueue and dequeue: count unchanged; FIFO order preserved.
- Pointers wrap modulo DEPTH.
- flush (takes priority over everything else):
  - count←0, head←tail.
  - A response arriving in the flush cycle is dropped.
  - stale←pending − in_valid, including any stale response dropped this cycle. A req_issue in the flush cycle is fresh: pending counts it, stale does not.
  - No dequeue occurs in the flush cycle.
- Overflow: an accepted response with count==DEPTH and no bypass consumption sets overflow=1 (sticky until reset); the response is discarded and state is otherwise unchanged.
- req_issue with pending==OUTSTANDING is ignored for pending; overflow is not set.
- Latency:
  - Bypass path: 0 cycles from in_valid to out_valid.
  - Stored path: 1 cycle.
  - Dequeue visibility: the next head is visible the cycle after the handshake.

Test Plan:
1. DEPTH=4, OUTSTANDING=1, out_ready=0; four issue/response pairs with pc 0x80000000, +4, +8, +C → count=4, fetch_allow=0. Then out_ready=1 → PCs drain in order, one per cycle; count reaches 0; fetch_allow returns to 1.
2. Empty queue, BYPASS=1, in_valid with pc=0x80000010, instr=0x00000013, out_ready=1 → same-cycle out_valid=1, out_pc=0x80000010; count stays 0. Repeat with BYPASS=0 → out_valid only on the next cycle.
3. req_issue; next cycle flush; following cycle in_valid pc=0x80000020 → response dropped, out_valid=0, count=0, stale 1→0. A later fresh response pc=0x80001000 is delivered.
4. pending=1 and flush, in_valid and req_issue all in one cycle → response dropped, pending=1, stale=0; the next response is delivered.
5. count=2 with in_valid and out_ready in the same cycle → count=2; output order preserved across the pointer wrap (DEPTH+3 total entries).
6. Two cases:
   - count=3, reset driven low between clock edges → all outputs go to reset values immediately, without waiting for an edge.
   - Separately, force in_valid at count=4 → overflow=1, which stays 1 until reset.

Source files
------------

// File: rtl/fetch_queue.sv
// In-order instruction fetch buffer between the ibus response path and decode.
// Credit-throttled issue, multiple outstanding requests, flush with stale-response drop, optional bypass.
module fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned OUTSTANDING = 1,
  parameter int unsigned PC_W        = 64,
  parameter int unsigned INSTR_W     = 32,
  parameter bit          BYPASS      = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     req_issue,
  output logic                     fetch_allow,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     in_exc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic                     out_exc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = $clog2(OUTSTANDING + 1);

  logic [AW-1:0]      head_q, head_d;
  logic [AW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [NW-1:0]      pending_q, pending_d;
  logic [NW-1:0]      stale_q, stale_d;
  logic               ovf_q, ovf_d;
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic               exc_mem_q   [DEPTH];

  logic [31:0] occ_s;
  logic        empty_s, full_s;
  logic        issue_s, resp_s, drop_stale_s, accept_s;
  logic        bypass_s, byp_take_s, deq_s, enq_s, ovf_set_s;

  assign occ_s        = 32'(count_q) + 32'(pending_q);
  assign empty_s      = (count_q == {CW{1'b0}});
  assign full_s       = (32'(count_q) == DEPTH);
  assign fetch_allow  = (occ_s < DEPTH) && (32'(pending_q) < OUTSTANDING);

  // A saturated request counter ignores further issues; a response with nothing pending is not counted.
  assign issue_s      = req_issue && (32'(pending_q) < OUTSTANDING);
  assign resp_s       = in_valid && (pending_q != {NW{1'b0}});
  assign drop_stale_s = in_valid && (stale_q != {NW{1'b0}});
  assign accept_s     = in_valid && (stale_q == {NW{1'b0}}) && !flush;

  assign bypass_s     = BYPASS && empty_s && accept_s;
  assign out_valid    = !flush && (!empty_s || bypass_s);
  assign deq_s        = out_valid && out_ready && !empty_s;
  assign byp_take_s   = bypass_s && out_ready;
  assign enq_s        = accept_s && !byp_take_s && !full_s;
  assign ovf_set_s    = accept_s && !byp_take_s && full_s;

  assign count        = count_q;
  assign overflow     = ovf_q;

  // Output field mux: stored head first, else the bypassed response, else zero.
  always_comb begin
    out_pc    = {PC_W{1'b0}};
    out_instr = {INSTR_W{1'b0}};
    out_exc   = 1'b0;
    if (flush) begin
      out_pc    = {PC_W{1'b0}};
      out_instr = {INSTR_W{1'b0}};
      out_exc   = 1'b0;
    end else if (!empty_s) begin
      out_pc    = pc_mem_q[head_q];
      out_instr = instr_mem_q[head_q];
      out_exc   = exc_mem_q[head_q];
    end else if (bypass_s) begin
      out_pc    = in_pc;
      out_instr = in_instr;
      out_exc   = in_exc;
    end else begin
      out_pc    = {PC_W{1'b0}};
      out_instr = {INSTR_W{1'b0}};
      out_exc   = 1'b0;
    end
  end

  // Next-state for pointers, occupancy, request tracking and the sticky error.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    stale_d   = stale_q;
    ovf_d     = ovf_q | ovf_set_s;
    pending_d = pending_q + NW'(issue_s) - NW'(resp_s);
    if (flush) begin
      // Everything in flight now belongs to the old path, except a request issued this cycle.
      count_d = {CW{1'b0}};
      head_d  = tail_q;
      stale_d = pending_q - NW'(resp_s);
    end else begin
      if (drop_stale_s) begin
        stale_d = stale_q - NW'(1'b1);
      end else begin
        stale_d = stale_q;
      end
      head_d  = head_q + AW'(deq_s);
      tail_d  = tail_q + AW'(enq_s);
      count_d = count_q + CW'(enq_s) - CW'(deq_s);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= {AW{1'b0}};
      tail_q    <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      pending_q <= {NW{1'b0}};
      stale_q   <= {NW{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
      ovf_q     <= ovf_d;
    end
  end

  // Entry storage, written at the tail on enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= {PC_W{1'b0}};
        instr_mem_q[i] <= {INSTR_W{1'b0}};
        exc_mem_q[i]   <= 1'b0;
      end
    end else if (enq_s) begin
      pc_mem_q[tail_q]    <= in_pc;
      instr_mem_q[tail_q] <= in_instr;
      exc_mem_q[tail_q]   <= in_exc;
    end else begin
      pc_mem_q[tail_q]    <= pc_mem_q[tail_q];
      instr_mem_q[tail_q] <= instr_mem_q[tail_q];
      exc_mem_q[tail_q]   <= exc_mem_q[tail_q];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based behavioural model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int OUTST = 2;

  logic        clk = 1'b0;
  logic        reset, flush, req_issue, in_valid, in_exc, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;

  logic        fetch_allow, out_valid, out_exc, overflow;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
  logic        fetch_allow0, out_valid0, out_exc0, overflow0;
  logic [63:0] out_pc0;
  logic [31:0] out_instr0;
  logic [2:0]  count0;

  fetch_queue #(.DEPTH(DEPTH), .OUTSTANDING(OUTST), .PC_W(64), .INSTR_W(32), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_issue(req_issue), .fetch_allow(fetch_allow),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_exc(out_exc), .count(count), .overflow(overflow));

  fetch_queue #(.DEPTH(DEPTH), .OUTSTANDING(OUTST), .PC_W(64), .INSTR_W(32), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .req_issue(req_issue), .fetch_allow(fetch_allow0),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0), .out_instr(out_instr0),
    .out_exc(out_exc0), .count(count0), .overflow(overflow0));

  always #5 clk = ~clk;

  typedef struct {logic [63:0] pc; logic [31:0] instr; logic exc;} ent_t;
  ent_t q[$];
  int   pend, stl;
  logic ovf;
  logic e_valid, e_allow, e_exc;
  logic [63:0] e_pc;
  logic [31:0] e_instr;
  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  function automatic bit accepted();
    return in_valid && stl == 0 && !flush;
  endfunction

  // Expected outputs for the current inputs, then compare the whole DUT output set.
  task automatic compare();
    bit byp;
    byp     = accepted() && q.size() == 0;
    e_allow = (q.size() + pend < DEPTH) && (pend < OUTST);
    e_valid = !flush && (q.size() > 0 || byp);
    e_pc = 64'd0; e_instr = 32'd0; e_exc = 1'b0;
    if (e_valid && q.size() > 0) begin
      e_pc = q[0].pc; e_instr = q[0].instr; e_exc = q[0].exc;
    end else if (e_valid) begin
      e_pc = in_pc; e_instr = in_instr; e_exc = in_exc;
    end
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_valid});
    chk("out_pc", out_pc, e_pc);
    chk("out_instr", {32'd0, out_instr}, {32'd0, e_instr});
    chk("out_exc", {63'd0, out_exc}, {63'd0, e_exc});
    chk("count", {61'd0, count}, 64'(q.size()));
    chk("fetch_allow", {63'd0, fetch_allow}, {63'd0, e_allow});
    chk("overflow", {63'd0, overflow}, {63'd0, ovf});
  endtask

  task automatic drive(input logic fl, input logic iss, input logic iv, input logic [63:0] pc,
                       input logic [31:0] ins, input logic ex, input logic rdy);
    @(negedge clk);
    flush = fl; req_issue = iss; in_valid = iv; in_pc = pc; in_instr = ins; in_exc = ex; out_ready = rdy;
    #1;
    compare();
  endtask

  // Advance the model across the clock edge using the inputs still applied.
  task automatic commit();
    int  sz, iv_real, iss_real;
    bit  acc, take;
    @(posedge clk);
    sz       = q.size();
    acc      = accepted();
    take     = acc && sz == 0 && out_ready;
    iv_real  = (in_valid && pend > 0) ? 1 : 0;
    iss_real = (req_issue && pend < OUTST) ? 1 : 0;
    if (flush) begin
      q.delete();
      stl = pend - iv_real;
    end else begin
      if (in_valid && stl > 0) stl--;
      if (out_ready && sz > 0) void'(q.pop_front());
      if (acc && !take) begin
        if (sz == DEPTH) ovf = 1'b1;
        else q.push_back('{pc: in_pc, instr: in_instr, exc: in_exc});
      end
    end
    pend = pend + iss_real - iv_real;
  endtask

  task automatic step(input logic fl, input logic iss, input logic iv, input logic [63:0] pc,
                      input logic [31:0] ins, input logic ex, input logic rdy);
    drive(fl, iss, iv, pc, ins, ex, rdy);
    commit();
  endtask

  task automatic model_reset();
    q.delete(); pend = 0; stl = 0; ovf = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; req_issue = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || pend > 0) && n < 50) begin
      step(1'b0, 1'b0, pend > 0, 64'h9000_0000 + 64'(n), 32'h13, 1'b0, 1'b1);
      n++;
    end
    chk("drain_bound", 64'(q.size() + pend), 64'd0);
  endtask

  task automatic fill(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, base + 64'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; req_issue = 1'b0; in_valid = 1'b0; in_exc = 1'b0;
    out_ready = 1'b0; in_pc = 64'd0; in_instr = 32'd0;
    model_reset();
    #12;
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_allow", {63'd0, fetch_allow}, 64'd1);
    chk("reset_count", {61'd0, count}, 64'd0);
    apply_reset();

    // Bypass on empty queue; the non-bypass instance shows it one cycle later.
    step(1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 64'h8000_0010, 32'h0000_0013, 1'b0, 1'b1);
    chk("byp_valid", {63'd0, out_valid}, 64'd1);
    chk("byp_pc", out_pc, 64'h8000_0010);
    chk("nobyp_valid0", {63'd0, out_valid0}, 64'd0);
    commit();
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    chk("byp_count", {61'd0, count}, 64'd0);
    chk("nobyp_valid1", {63'd0, out_valid0}, 64'd1);
    chk("nobyp_pc", out_pc0, 64'h8000_0010);
    commit();

    // Fill to DEPTH with decode stalled, then drain in order.
    fill(4, 64'h8000_0000);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    chk("full_count", {61'd0, count}, 64'd4);
    chk("full_allow", {63'd0, fetch_allow}, 64'd0);
    commit();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
      chk("drain_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
      commit();
    end
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    chk("empty_allow", {63'd0, fetch_allow}, 64'd1);
    commit();

    // Flush with one request in flight: its response is stale and dropped.
    step(1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 64'h8000_0020, 32'h13, 1'b0, 1'b1);
    chk("stale_valid", {63'd0, out_valid}, 64'd0);
    commit();
    step(1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 64'h8000_1000, 32'h33, 1'b0, 1'b1);
    chk("fresh_pc", out_pc, 64'h8000_1000);
    commit();

    // Flush, response and new issue in one cycle: the new request stays fresh.
    step(1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 64'h8000_0030, 32'h13, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 64'h8000_2000, 32'h44, 1'b1, 1'b1);
    chk("post_flush_valid", {63'd0, out_valid}, 64'd1);
    chk("post_flush_pc", out_pc, 64'h8000_2000);
    commit();

    // Steady count=2 with concurrent enqueue/dequeue across the pointer wrap.
    fill(2, 64'h8000_3000);
    step(1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 64'h8000_3008 + 64'(4 * i), 32'h2000 + 32'(i), 1'b0, 1'b1);
      chk("wrap_pc", out_pc, 64'h8000_3000 + 64'(4 * i));
      commit();
      drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      chk("wrap_count", {61'd0, count}, 64'd2);
      commit();
    end
    drain();

    // Asynchronous reset between edges with three stored entries.
    fill(3, 64'h8000_4000);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("areset_valid", {63'd0, out_valid}, 64'd0);
    chk("areset_pc", out_pc, 64'd0);
    chk("areset_count", {61'd0, count}, 64'd0);
    chk("areset_allow", {63'd0, fetch_allow}, 64'd1);
    model_reset();
    @(negedge clk) reset = 1'b1;

    // Forced response into a full queue sets the sticky overflow.
    fill(4, 64'h8000_5000);
    step(1'b0, 1'b0, 1'b1, 64'h8000_6000, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      chk("ovf_sticky", {63'd0, overflow}, 64'd1);
      chk("ovf_count", {61'd0, count}, 64'd4);
      commit();
    end
    drain();
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    chk("ovf_after_drain", {63'd0, overflow}, 64'd1);
    commit();
    apply_reset();
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    chk("ovf_cleared", {63'd0, overflow}, 64'd0);
    commit();

    // Randomized legal traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic iss, iv, fl;
      fl  = ($urandom_range(0, 19) == 0);
      iss = (q.size() + pend < DEPTH) && (pend < OUTST) && ($urandom_range(0, 2) != 0);
      iv  = (pend > 0) && ($urandom_range(0, 1) == 1);
      step(fl, iss, iv, {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
